rf_spi_arbiter: RTL

Command arbiter and sequencer in front of the radio SPI transaction engine. It accepts short/long register read/write commands from up to NREQ requesters (e.g. init sequencer, TX path, interrupt service) and grants them round-robin. It drives the engine's start/mode/address/data inputs and holds them stable for the whole transaction. It deserializes the read byte from the engine's serial data output and returns one response per command, with a timeout error if the engine never completes.

---
 rtl/rf_spi_arbiter_if.sv | 35 +++
 rtl/rf_spi_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rf_spi_arbiter_if.sv
// Requester-side and engine-side signals of the radio SPI command arbiter.
// The slave modport is the arbiter's view, and the master modport is the environment's view.
interface rf_spi_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req;
  logic [2*NREQ-1:0]  req_mode;
  logic [10*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0]  req_wdata;
  logic [NREQ-1:0]    gnt;
  logic               resp_valid;
  logic [1:0]         resp_id;
  logic [7:0]         resp_rdata;
  logic               resp_err;
  logic               busy;
  logic               eng_c_en;
  logic [1:0]         eng_mode;
  logic [9:0]         eng_addr;
  logic [7:0]         eng_wdata;
  logic               eng_ready;
  logic               eng_cs;
  logic               eng_sdo;

  modport slave (
    input  req, req_mode, req_addr, req_wdata, eng_ready, eng_cs, eng_sdo,
    output gnt, resp_valid, resp_id, resp_rdata, resp_err, busy,
           eng_c_en, eng_mode, eng_addr, eng_wdata
  );

  modport master (
    output req, req_mode, req_addr, req_wdata, eng_ready, eng_cs, eng_sdo,
    input  gnt, resp_valid, resp_id, resp_rdata, resp_err, busy,
           eng_c_en, eng_mode, eng_addr, eng_wdata
  );
endinterface

// File: rtl/rf_spi_arbiter.sv
// Round-robin command arbiter in front of the radio SPI engine. It runs one transaction at a time,
// deserializes the read byte, and returns exactly one response per grant, with an error response on timeout.
module rf_spi_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  rf_spi_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  logic [1:0]      state_r;
  logic [CW-1:0]   cnt_r;
  logic [7:0]      shift_r;
  logic [1:0]      last_r;
  logic [1:0]      id_r;
  logic [3:0]      req_pad_s;
  logic [7:0]      mode_pad_s;
  logic [39:0]     addr_pad_s;
  logic [31:0]     wdata_pad_s;
  logic [2:0]      idx_s;
  logic [1:0]      winner_s;
  logic            found_s;
  logic [NREQ-1:0] gnt_s;
  logic [1:0]      win_mode_s;
  logic [9:0]      win_addr_s;
  logic [7:0]      win_wdata_s;
  logic [CW-1:0]   cnt_next_s;
  logic            expired_s;

  // Round-robin search starting one past the last served requester
  always_comb begin
    req_pad_s = 4'(bus.req);
    idx_s     = 3'd0;
    winner_s  = 2'd0;
    found_s   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = {1'b0, last_r} + 3'(k);
      if (idx_s >= 3'(NREQ)) begin
        idx_s = idx_s - 3'(NREQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_pad_s[idx_s[1:0]]) begin
        winner_s = idx_s[1:0];
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      gnt_s[i] = (winner_s == 2'(i));
    end
  end

  // Payload mux for the winning requester
  always_comb begin
    mode_pad_s  = 8'(bus.req_mode);
    addr_pad_s  = 40'(bus.req_addr);
    wdata_pad_s = 32'(bus.req_wdata);
    case (winner_s)
      2'd0: begin
        win_mode_s = mode_pad_s[1:0]; win_addr_s = addr_pad_s[9:0];   win_wdata_s = wdata_pad_s[7:0];
      end
      2'd1: begin
        win_mode_s = mode_pad_s[3:2]; win_addr_s = addr_pad_s[19:10]; win_wdata_s = wdata_pad_s[15:8];
      end
      2'd2: begin
        win_mode_s = mode_pad_s[5:4]; win_addr_s = addr_pad_s[29:20]; win_wdata_s = wdata_pad_s[23:16];
      end
      default: begin
        win_mode_s = mode_pad_s[7:6]; win_addr_s = addr_pad_s[39:30]; win_wdata_s = wdata_pad_s[31:24];
      end
    endcase
  end

  // Timeout detection: the count reaches the limit on this edge
  always_comb begin
    cnt_next_s = cnt_r + CW'(1'b1);
    expired_s  = (cnt_next_s == TO_LIM);
  end

  // Sequencer, engine drive and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= S_IDLE;
      cnt_r           <= {CW{1'b0}};
      shift_r         <= 8'h00;
      last_r          <= 2'(NREQ - 1);
      id_r            <= 2'd0;
      bus.gnt         <= {NREQ{1'b0}};
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= 2'd0;
      bus.resp_rdata  <= 8'h00;
      bus.resp_err    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.eng_c_en    <= 1'b0;
      bus.eng_mode    <= 2'd0;
      bus.eng_addr    <= 10'd0;
      bus.eng_wdata   <= 8'h00;
    end else begin
      bus.gnt        <= {NREQ{1'b0}};
      bus.resp_valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (found_s && bus.eng_ready && bus.eng_cs) begin
            bus.gnt       <= gnt_s;
            bus.eng_mode  <= win_mode_s;
            bus.eng_addr  <= win_addr_s;
            bus.eng_wdata <= win_wdata_s;
            bus.eng_c_en  <= 1'b1;
            bus.busy      <= 1'b1;
            id_r          <= winner_s;
            cnt_r         <= {CW{1'b0}};
            shift_r       <= 8'h00;
            state_r       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_r <= cnt_next_s;
          if (expired_s) begin
            bus.eng_c_en   <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_id    <= id_r;
            bus.resp_rdata <= 8'h00;
            bus.resp_err   <= 1'b1;
            state_r        <= S_RESP;
          end else if (!bus.eng_cs) begin
            bus.eng_c_en <= 1'b0;
            state_r      <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_r <= cnt_next_s;
          if (bus.eng_cs) begin
            bus.resp_valid <= 1'b1;
            bus.resp_id    <= id_r;
            bus.resp_rdata <= bus.eng_mode[0] ? 8'h00 : shift_r;
            bus.resp_err   <= 1'b0;
            state_r        <= S_RESP;
          end else if (expired_s) begin
            bus.resp_valid <= 1'b1;
            bus.resp_id    <= id_r;
            bus.resp_rdata <= 8'h00;
            bus.resp_err   <= 1'b1;
            state_r        <= S_RESP;
          end else begin
            shift_r <= {shift_r[6:0], bus.eng_sdo};
          end
        end
        S_RESP: begin
          last_r         <= id_r;
          bus.resp_id    <= 2'd0;
          bus.resp_rdata <= 8'h00;
          bus.resp_err   <= 1'b0;
          bus.busy       <= 1'b0;
          state_r        <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
